health_alarm_monitor: RTL and testbench
=======================================

# health_alarm_monitor

Multi-channel, parametrised successor to the phase-1 combinational abnormality detectors. Each channel compares a streamed unsigned sensor sample against run-time low/high thresholds and raises a latched low or high alarm only after `PERSIST` consecutive out-of-range valid samples. Alarms hold until acknowledged, and each channel keeps a saturating alarm-event counter. The block sits between the sensor front-ends and the phase-2 alarm/reporting logic.

## Interface
- `CH`, 4, number of independent channels
- `DW`, 8, sample and threshold width (unsigned)
- `PERSIST`, 3, consecutive abnormal valid samples required to raise an alarm (≥1)
- `CNTW`, 8, per-channel event counter width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_valid`  in  1  `sample_data` valid this cycle for all channels
- `sample_data`  in  CH*DW  channel i at bits [i*DW +: DW]
- `low_thr`  in  CH*DW  per-channel low threshold, same packing
- `high_thr`  in  CH*DW  per-channel high threshold, same packing
- `ch_enable`  in  CH  per-channel enable
- `alarm_ack`  in  CH  per-channel alarm acknowledge, level-sampled
- `low_alarm`  out  CH  latched low alarm per channel
- `high_alarm`  out  CH  latched high alarm per channel
- `alarm_any`  out  1  registered OR of all `low_alarm` and `high_alarm` bits
- `event_count`  out  CH*CNTW  saturating count of alarm entries, channel i at [i*CNTW +: CNTW]

## Operation
- Classification per valid sample, unsigned:
  - LOW if `data < low_thr`.
  - else HIGH if `data > high_thr`.
  - else OK.
  - Equality counts as OK. LOW has priority when thresholds are inverted.
- Per-channel FSM states: NORMAL, PEND_LOW, PEND_HIGH, ALM_LOW, ALM_HIGH. Each channel has a run counter of width clog2(PERSIST+1).
- NORMAL:
  - LOW sample → PEND_LOW, run=1.
  - HIGH sample → PEND_HIGH, run=1.
  - If PERSIST=1, go directly to ALM_* instead.
- PEND_x:
  - Same-direction sample: run+1. When run reaches PERSIST → ALM_x.
  - Opposite-direction sample → PEND of the other direction, run=1.
  - OK sample → NORMAL, run=0.
- ALM_x:
  - Holds regardless of further samples, including OK or opposite-direction samples.
  - Exits only on `alarm_ack[i]`=1 → NORMAL, run=0.
  - A sample arriving in the ack cycle is discarded for that channel.
- `alarm_ack` in any non-alarm state is ignored.
- `sample_valid`=0: all FSMs and run counters hold.
- `ch_enable[i]`=0: channel forced to NORMAL, run=0, alarms 0. `event_count` holds and is not cleared.
- Event counter: +1 on each transition into ALM_LOW or ALM_HIGH. Saturates at 2^CNTW−1 with no wrap.
- Outputs: `low_alarm[i]` = (state==ALM_LOW), `high_alarm[i]` = (state==ALM_HIGH). Both are registered and never high together.
- Thresholds are sampled in the same cycle as `sample_valid`. They may change on any cycle.

## Timing
- Reset (`rst`=1 at posedge): all FSMs NORMAL, run=0, `low_alarm`=0, `high_alarm`=0, `alarm_any`=0, all `event_count`=0. Reset wins over every other input.
- Reset mid-pending or mid-alarm: state discarded, no event counted.
- Throughput: one sample set per cycle, no backpressure.
- Alarm latency:
  - The alarm output rises on the clock edge that registers the PERSIST-th consecutive abnormal valid sample. It is visible 1 cycle after that sample is presented.
  - `event_count` updates on the same edge.
- `alarm_any` lags the alarm bits by one cycle (registered OR).
- Ack latency: alarm falls on the edge where `alarm_ack`=1 is sampled. The earliest re-raise is PERSIST valid samples later.
- Non-consecutive abnormal samples, i.e. with an OK sample in between, never raise an alarm. Invalid cycles between abnormal samples do not break the run.

## Test plan
- CH=4, DW=8, PERSIST=3. Ch0 thr 50/200, data 40,40,40 on consecutive valid cycles:
  - `low_alarm[0]`=1 the cycle after the third sample.
  - `event_count[0]`=1.
  - `alarm_any`=1 one cycle later.
  - Other channels stay at 0.
- Ch1 data sequence 210,210,100,210,210 → no alarm. Then 210 (third consecutive) → `high_alarm[1]`=1. Also check that data=200 and data=50 classify as OK.
- Ch2 raises a high alarm, then data=100 for 5 cycles → alarm stays 1. Pulse `alarm_ack[2]` for 1 cycle with data=250 → alarm 0 that edge. Then 250×3 → alarm re-raises and `event_count[2]`=2.
- Ch3 LOW, LOW, HIGH, HIGH, HIGH → only `high_alarm[3]`, after the 5th sample. `sample_valid`=0 gaps inserted between those samples → same result.
- CNTW=2: raise and ack ch0 five times → `event_count[0]` sticks at 3. Clear `ch_enable[0]` during PEND_LOW → alarm never raised. Assert `rst` while ch1 is in alarm → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/health_alarm_monitor.sv
// Multi-channel threshold monitor. Each channel latches a low/high alarm after
// PERSIST consecutive out-of-range valid samples. Alarms are held until acknowledged.
module health_alarm_monitor #(
  parameter int CH      = 4,
  parameter int DW      = 8,
  parameter int PERSIST = 3,
  parameter int CNTW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [CH*DW-1:0]   sample_data,
  input  logic [CH*DW-1:0]   low_thr,
  input  logic [CH*DW-1:0]   high_thr,
  input  logic [CH-1:0]      ch_enable,
  input  logic [CH-1:0]      alarm_ack,
  output logic [CH-1:0]      low_alarm,
  output logic [CH-1:0]      high_alarm,
  output logic               alarm_any,
  output logic [CH*CNTW-1:0] event_count
);

  localparam int RW = $clog2(PERSIST + 1);
  localparam logic [RW-1:0]   RUN_LAST = RW'(PERSIST - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_NORMAL,
    S_PEND_LOW,
    S_PEND_HIGH,
    S_ALM_LOW,
    S_ALM_HIGH
  } state_t;

  logic [CH-1:0] w_low_alarm;
  logic [CH-1:0] w_high_alarm;
  logic          r_alarm_any;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      state_t          r_state, w_state_next;
      logic [RW-1:0]   r_run, w_run_next;
      logic [RW-1:0]   w_run_base;
      logic [CNTW-1:0] r_count;
      logic            w_enter;
      logic [DW-1:0]   w_data, w_lo, w_hi;
      logic            w_is_low, w_is_high;

      assign w_data    = sample_data[gi*DW +: DW];
      assign w_lo      = low_thr[gi*DW +: DW];
      assign w_hi      = high_thr[gi*DW +: DW];
      // LOW wins when the thresholds are inverted; equality is in range.
      assign w_is_low  = (w_data < w_lo);
      assign w_is_high = !w_is_low && (w_data > w_hi);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= S_NORMAL;
          r_run   <= '0;
          r_count <= '0;
        end else begin
          r_state <= w_state_next;
          r_run   <= w_run_next;
          if (w_enter && (r_count != CNT_MAX)) r_count <= r_count + 1'b1;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        w_enter      = 1'b0;
        w_run_base   = '0;
        if (!ch_enable[gi]) begin
          w_state_next = S_NORMAL;
          w_run_next   = '0;
        end else begin
          case (r_state)
            S_ALM_LOW, S_ALM_HIGH: begin
              if (alarm_ack[gi]) begin
                w_state_next = S_NORMAL;
                w_run_next   = '0;
              end
            end
            default: begin
              if (sample_valid) begin
                // A run continues only in the same direction; otherwise it restarts at 1.
                if (w_is_low) begin
                  w_run_base = (r_state == S_PEND_LOW) ? r_run : '0;
                  if (w_run_base == RUN_LAST) begin
                    w_state_next = S_ALM_LOW;
                    w_run_next   = '0;
                    w_enter      = 1'b1;
                  end else begin
                    w_state_next = S_PEND_LOW;
                    w_run_next   = w_run_base + 1'b1;
                  end
                end else if (w_is_high) begin
                  w_run_base = (r_state == S_PEND_HIGH) ? r_run : '0;
                  if (w_run_base == RUN_LAST) begin
                    w_state_next = S_ALM_HIGH;
                    w_run_next   = '0;
                    w_enter      = 1'b1;
                  end else begin
                    w_state_next = S_PEND_HIGH;
                    w_run_next   = w_run_base + 1'b1;
                  end
                end else begin
                  w_state_next = S_NORMAL;
                  w_run_next   = '0;
                end
              end
            end
          endcase
        end
      end

      assign w_low_alarm[gi]                = (r_state == S_ALM_LOW);
      assign w_high_alarm[gi]               = (r_state == S_ALM_HIGH);
      assign event_count[gi*CNTW +: CNTW]   = r_count;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_alarm_any <= 1'b0;
    else     r_alarm_any <= |{w_low_alarm, w_high_alarm};
  end

  assign low_alarm  = w_low_alarm;
  assign high_alarm = w_high_alarm;
  assign alarm_any  = r_alarm_any;

endmodule

// File: tb/tb_health_alarm_monitor.sv
// Directed bench for health_alarm_monitor; a second instance with CNTW=2
// shares all inputs to exercise counter saturation.
module tb_health_alarm_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [31:0] low_thr;
  logic [31:0] high_thr;
  logic [3:0]  ch_enable;
  logic [3:0]  alarm_ack;
  logic [3:0]  low_alarm, high_alarm;
  logic        alarm_any;
  logic [31:0] event_count;
  logic [3:0]  low_alarm2, high_alarm2;
  logic        alarm_any2;
  logic [7:0]  event_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  health_alarm_monitor #(.CH(4), .DW(8), .PERSIST(3), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .low_thr(low_thr), .high_thr(high_thr), .ch_enable(ch_enable), .alarm_ack(alarm_ack),
    .low_alarm(low_alarm), .high_alarm(high_alarm), .alarm_any(alarm_any),
    .event_count(event_count)
  );

  health_alarm_monitor #(.CH(4), .DW(8), .PERSIST(3), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .low_thr(low_thr), .high_thr(high_thr), .ch_enable(ch_enable), .alarm_ack(alarm_ack),
    .low_alarm(low_alarm2), .high_alarm(high_alarm2), .alarm_any(alarm_any2),
    .event_count(event_count2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    sample_data[ch*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_vec++;
    if (low_alarm !== 4'b0000) begin n_err++; $display("FAIL reset_low got=%b exp=0000", low_alarm); end
    n_vec++;
    if (high_alarm !== 4'b0000) begin n_err++; $display("FAIL reset_high got=%b exp=0000", high_alarm); end
    n_vec++;
    if (alarm_any !== 1'b0) begin n_err++; $display("FAIL reset_any got=%b exp=0", alarm_any); end
    n_vec++;
    if (event_count !== 32'h0) begin n_err++; $display("FAIL reset_count got=%h exp=0", event_count); end
    $display("test_reset done");
  endtask

  task automatic test_low_persist();
    sample_valid = 1'b1;
    set_data(0, 8'd40);
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++;
      if (low_alarm !== 4'b0000) begin n_err++; $display("FAIL low_early[%0d] got=%b exp=0000", i, low_alarm); end
    end
    cyc();
    n_vec++;
    if (low_alarm !== 4'b0001) begin n_err++; $display("FAIL low_raise got=%b exp=0001", low_alarm); end
    n_vec++;
    if (high_alarm !== 4'b0000) begin n_err++; $display("FAIL low_raise_high got=%b exp=0000", high_alarm); end
    n_vec++;
    if (event_count[7:0] !== 8'd1) begin n_err++; $display("FAIL low_count got=%0d exp=1", event_count[7:0]); end
    n_vec++;
    if (alarm_any !== 1'b0) begin n_err++; $display("FAIL low_any_lag got=%b exp=0", alarm_any); end
    sample_valid = 1'b0;
    set_data(0, 8'd100);
    cyc();
    n_vec++;
    if (alarm_any !== 1'b1) begin n_err++; $display("FAIL low_any got=%b exp=1", alarm_any); end
    alarm_ack = 4'b0001;
    cyc();
    alarm_ack = 4'b0000;
    n_vec++;
    if (low_alarm !== 4'b0000) begin n_err++; $display("FAIL low_ack got=%b exp=0000", low_alarm); end
    $display("test_low_persist done");
  endtask

  task automatic test_high_nonconsec();
    logic [7:0] seq [6];
    seq = '{8'd210, 8'd210, 8'd100, 8'd210, 8'd210, 8'd210};
    sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_data(1, seq[i]);
      cyc();
      n_vec++;
      if (high_alarm !== ((i == 5) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL high_seq[%0d] got=%b exp=%b", i, high_alarm, (i == 5) ? 4'b0010 : 4'b0000);
      end
    end
    n_vec++;
    if (event_count[15:8] !== 8'd1) begin n_err++; $display("FAIL high_count got=%0d exp=1", event_count[15:8]); end
    alarm_ack = 4'b0010;
    set_data(1, 8'd100);
    cyc();
    alarm_ack = 4'b0000;
    // Samples equal to either threshold are in range.
    set_data(1, 8'd200);
    set_data(2, 8'd50);
    for (int i = 0; i < 4; i++) cyc();
    n_vec++;
    if ({low_alarm, high_alarm} !== 8'h00) begin
      n_err++; $display("FAIL equal_ok got=%b_%b exp=0000_0000", low_alarm, high_alarm);
    end
    set_data(1, 8'd100);
    set_data(2, 8'd100);
    cyc();
    $display("test_high_nonconsec done");
  endtask

  task automatic test_ack_hold();
    sample_valid = 1'b1;
    set_data(2, 8'd250);
    for (int i = 0; i < 3; i++) cyc();
    n_vec++;
    if (high_alarm !== 4'b0100) begin n_err++; $display("FAIL hold_raise got=%b exp=0100", high_alarm); end
    set_data(2, 8'd100);
    for (int i = 0; i < 5; i++) cyc();
    n_vec++;
    if (high_alarm !== 4'b0100) begin n_err++; $display("FAIL hold_ok got=%b exp=0100", high_alarm); end
    set_data(2, 8'd250);
    alarm_ack = 4'b0100;
    cyc();
    alarm_ack = 4'b0000;
    n_vec++;
    if (high_alarm !== 4'b0000) begin n_err++; $display("FAIL hold_ack got=%b exp=0000", high_alarm); end
    cyc();
    cyc();
    n_vec++;
    if (high_alarm !== 4'b0000) begin n_err++; $display("FAIL hold_rearm_early got=%b exp=0000", high_alarm); end
    cyc();
    n_vec++;
    if (high_alarm !== 4'b0100) begin n_err++; $display("FAIL hold_reraise got=%b exp=0100", high_alarm); end
    n_vec++;
    if (event_count[23:16] !== 8'd2) begin n_err++; $display("FAIL hold_count got=%0d exp=2", event_count[23:16]); end
    set_data(2, 8'd100);
    alarm_ack = 4'b0100;
    cyc();
    alarm_ack = 4'b0000;
    $display("test_ack_hold done");
  endtask

  task automatic test_dir_change();
    logic [7:0] seq [5];
    seq = '{8'd20, 8'd20, 8'd230, 8'd230, 8'd230};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        sample_valid = 1'b1;
        set_data(3, seq[i]);
        cyc();
        n_vec++;
        if ({low_alarm[3], high_alarm[3]} !== ((i == 4) ? 2'b01 : 2'b00)) begin
          n_err++; $display("FAIL dir[%0d][%0d] got=%b%b exp=%b", pass, i, low_alarm[3], high_alarm[3],
                            (i == 4) ? 2'b01 : 2'b00);
        end
        if (pass == 1 && i < 4) begin
          // Gap cycle with in-range data that must be ignored.
          sample_valid = 1'b0;
          set_data(3, 8'd100);
          cyc();
        end
      end
      sample_valid = 1'b0;
      set_data(3, 8'd100);
      alarm_ack = 4'b1000;
      cyc();
      alarm_ack = 4'b0000;
    end
    n_vec++;
    if (event_count[31:24] !== 8'd2) begin n_err++; $display("FAIL dir_count got=%0d exp=2", event_count[31:24]); end
    $display("test_dir_change done");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1;
      set_data(0, 8'd40);
      for (int i = 0; i < 3; i++) cyc();
      n_vec++;
      if (low_alarm2[0] !== 1'b1) begin n_err++; $display("FAIL sat_raise[%0d] got=%b exp=1", k, low_alarm2[0]); end
      set_data(0, 8'd100);
      alarm_ack = 4'b0001;
      cyc();
      alarm_ack = 4'b0000;
    end
    n_vec++;
    if (event_count2[1:0] !== 2'd3) begin n_err++; $display("FAIL sat_count2 got=%0d exp=3", event_count2[1:0]); end
    n_vec++;
    if (event_count[7:0] !== 8'd5) begin n_err++; $display("FAIL sat_count8 got=%0d exp=5", event_count[7:0]); end
    $display("test_saturate done");
  endtask

  task automatic test_enable();
    sample_valid = 1'b1;
    set_data(0, 8'd40);
    cyc();
    cyc();
    ch_enable = 4'b1110;
    cyc();
    n_vec++;
    if (low_alarm[0] !== 1'b0) begin n_err++; $display("FAIL en_off got=%b exp=0", low_alarm[0]); end
    ch_enable = 4'b1111;
    cyc();
    cyc();
    n_vec++;
    if (low_alarm[0] !== 1'b0) begin n_err++; $display("FAIL en_run_cleared got=%b exp=0", low_alarm[0]); end
    n_vec++;
    if (event_count[7:0] !== 8'd5) begin n_err++; $display("FAIL en_count got=%0d exp=5", event_count[7:0]); end
    set_data(0, 8'd100);
    cyc();
    $display("test_enable done");
  endtask

  task automatic test_reset_mid_alarm();
    sample_valid = 1'b1;
    set_data(1, 8'd210);
    for (int i = 0; i < 3; i++) cyc();
    sample_valid = 1'b0;
    cyc();
    n_vec++;
    if ({high_alarm, alarm_any} !== 5'b0010_1) begin
      n_err++; $display("FAIL rstmid_pre got=%b_%b exp=0010_1", high_alarm, alarm_any);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if ({low_alarm, high_alarm, alarm_any} !== 9'b0) begin
      n_err++; $display("FAIL rstmid_alarms got=%b_%b_%b exp=0", low_alarm, high_alarm, alarm_any);
    end
    n_vec++;
    if (event_count !== 32'h0 || event_count2 !== 8'h0) begin
      n_err++; $display("FAIL rstmid_count got=%h/%h exp=0/0", event_count, event_count2);
    end
    set_data(1, 8'd100);
    $display("test_reset_mid_alarm done");
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = {4{8'd100}};
    low_thr      = {4{8'd50}};
    high_thr     = {4{8'd200}};
    ch_enable    = 4'b1111;
    alarm_ack    = 4'b0000;
    test_reset();
    test_low_persist();
    test_high_nonconsec();
    test_ack_hold();
    test_dir_change();
    test_saturate();
    test_enable();
    test_reset_mid_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
